product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 24, accumulator/result width in bits (legal range 17..32).
REQ-002 SHALL have parameter CNT_W, default 8, width of the product-count field.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request a new accumulation run; sampled only in IDLE.
REQ-006 SHALL have port len  input  CNT_W  number of products in the run; sampled with start.
REQ-007 SHALL have port prod  input  16  unsigned 8x8 multiplier product from the upstream multiplier.
REQ-008 SHALL have port prod_valid  input  1  prod holds a valid product.
REQ-009 SHALL have port prod_ready  output  1  block accepts prod this cycle.
REQ-010 SHALL have port acc_out  output  ACC_W  accumulated result.
REQ-011 SHALL have port acc_valid  output  1  acc_out holds a completed result.
REQ-012 SHALL have port acc_ready  input  1  downstream accepts acc_out.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port ovf  output  1  an overflow occurred during the current or last run (sticky per run).

Function
REQ-015 SHALL implement a three-state FSM with states IDLE, ACC and DONE.
REQ-016 In IDLE with start=1 and len!=0, SHALL clear acc_out and ovf, load the counter with len, and go to ACC next cycle.
REQ-017 In IDLE with start=1 and len==0, SHALL clear acc_out and ovf and go directly to DONE, producing result 0.
REQ-018 prod_ready SHALL be 1 exactly while in ACC; it SHALL be a registered state decode with no combinational path from prod_valid.
REQ-019 A product SHALL be accepted only on a cycle with prod_valid=1 and prod_ready=1; it SHALL be added to acc_out zero-extended to ACC_W, and the counter SHALL decrement.
REQ-020 Acceptance of the len-th product SHALL move the FSM to DONE; acc_valid SHALL rise on the next cycle with the final sum (latency one cycle after the last handshake).
REQ-021 prod_valid=0 in ACC SHALL cause a stall with no state change; there is no timeout.
REQ-022 In DONE, acc_valid SHALL be 1 and acc_out and ovf SHALL hold stable until acc_ready=1; the FSM SHALL then return to IDLE on the next cycle.
REQ-023 acc_out SHALL retain its last value in IDLE.
REQ-024 start SHALL be ignored in ACC and DONE; a start in the same cycle as the DONE->IDLE handshake SHALL be ignored.
REQ-025 Without saturation, an addition producing a carry out of bit ACC_W-1 SHALL wrap modulo 2^ACC_W and set ovf.

Reset
REQ-026 While rst=1 on a clock edge, the block SHALL enter IDLE with acc_out=0, ovf=0, acc_valid=0, prod_ready=0, busy=0 and counter=0.
REQ-027 rst SHALL take priority over all other inputs in any state, including mid-run in ACC or DONE, and the partial result SHALL be discarded.

Configuration
REQ-028 Macro ACC_SAT_EN, when defined, SHALL make an overflowing addition clamp acc_out to 2^ACC_W-1, hold it there for the rest of the run, and set ovf.
REQ-029 Without ACC_SAT_EN, the wrap behaviour of REQ-025 SHALL apply; ovf, handshakes and timing SHALL be identical in both builds.

Verification
REQ-030 Basic run: ACC_W=24, start with len=3, products 0xFE01, 0x0001, 0x00FF with valid held high -> three consecutive accepts, acc_valid one cycle later, acc_out=0x00FF01, ovf=0.
REQ-031 Stall and backpressure: len=2, prod_valid toggled 1,0,0,1 with 0x0010 and 0x0020, acc_ready held low 5 cycles -> acc_out=0x000030 stable with acc_valid=1 for all 5 cycles, IDLE one cycle after acc_ready=1.
REQ-032 Overflow: ACC_W=17, len=3, three products 0xFE01 -> without ACC_SAT_EN acc_out=0x0FA03 and ovf=1; with ACC_SAT_EN acc_out=0x1FFFF and ovf=1.
REQ-033 Zero length: start with len=0 -> DONE next cycle, acc_out=0, acc_valid=1, prod_ready never asserted.
REQ-034 Mid-run reset: len=4, rst=1 asserted after the 2nd accept -> next cycle IDLE, acc_out=0, busy=0, prod_ready=0; a subsequent run with len=1 and product 0x0005 gives acc_out=0x000005.
REQ-035 Ignored start: start pulsed with len=9 during ACC and DONE of a len=1 run -> exactly one product accepted and one result produced, no second run.

Source files
------------

// File: rtl/product_accumulator.sv
// product_accumulator: accumulates len unsigned 16-bit products into an ACC_W-bit result.
// Define ACC_SAT_EN to saturate on overflow instead of wrapping.
module product_accumulator #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [15:0]      prod,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             busy,
    output logic             ovf
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    state_t state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, acc_add;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic ovf_q, ovf_d;
    logic [ACC_W:0] sum;
    assign sum = {1'b0, acc_q} + (ACC_W+1)'(prod);
`ifdef ACC_SAT_EN
    // once clamped, the sum stays pinned at full scale for the rest of the run
    assign acc_add = (sum[ACC_W] || ovf_q) ? '1 : sum[ACC_W-1:0];
`else
    assign acc_add = sum[ACC_W-1:0];
`endif
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (start) begin
                acc_d   = '0;
                ovf_d   = 1'b0;
                cnt_d   = len;
                state_d = (len == '0) ? DONE : ACC;
            end
            ACC: if (prod_valid) begin
                acc_d   = acc_add;
                ovf_d   = ovf_q | sum[ACC_W];
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = (cnt_q == CNT_W'(1)) ? DONE : ACC;
            end
            DONE: if (acc_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end
    assign prod_ready = (state_q == ACC);
    assign acc_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign acc_out    = acc_q;
    assign ovf        = ovf_q;
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: randomized checks of product_accumulator at ACC_W=24 and ACC_W=17 against a sum-of-products model.
// Follows ACC_SAT_EN so the model matches whichever build is compiled.
module tb_product_accumulator;
    logic clk = 1'b0;
    logic rst, start, prod_valid, acc_ready;
    logic [7:0] len;
    logic [15:0] prod;
    logic prod_ready, acc_valid, busy, ovf24;
    logic [23:0] acc24;
    logic prod_ready17, acc_valid17, busy17, ovf17;
    logic [16:0] acc17;
    int tests = 0, fails = 0;
    logic [15:0] prods[$];

    always #5 clk = ~clk;

    product_accumulator #(.ACC_W(24), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .prod(prod), .prod_valid(prod_valid),
        .prod_ready(prod_ready), .acc_out(acc24), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .busy(busy), .ovf(ovf24));
    product_accumulator #(.ACC_W(17), .CNT_W(8)) dut17 (
        .clk(clk), .rst(rst), .start(start), .len(len), .prod(prod), .prod_valid(prod_valid),
        .prod_ready(prod_ready17), .acc_out(acc17), .acc_valid(acc_valid17), .acc_ready(acc_ready),
        .busy(busy17), .ovf(ovf17));

    // result of summing the first n queued products into a w-bit accumulator
    function automatic void model(input int n, input int w, output logic [31:0] acc, output logic o);
        longint t = 0;
        longint lim = longint'(1) << w;
        for (int i = 0; i < n; i++) t += longint'(prods[i]);
        o = (t >= lim);
`ifdef ACC_SAT_EN
        acc = o ? 32'(lim - 1) : 32'(t);
`else
        acc = 32'(t % lim);
`endif
    endfunction

    // gap<0 selects the fixed valid pattern 1,0,0,1; noise keeps start high with len=9 during the run
    task automatic run_txn(input int n, input int gap, input int hold, input bit noise,
                           output int n_acc, output int lat, output int last,
                           output logic [23:0] a24, output logic [16:0] a17, output logic o24, output logic o17,
                           output bit stable, output bit idle_ok, output int rdy, output bit to);
        int idx = 0, cyc = 0;
        n_acc = 0; last = -1; lat = -1; stable = 1; idle_ok = 0; rdy = 0; to = 0;
        @(posedge clk); #1;
        start = 1; len = n[7:0];
        @(posedge clk); #1;
        start = noise; len = 8'd9;
        forever begin
            prod_valid = (idx < n) && ((gap < 0) ? (cyc % 3 == 0) : ($urandom_range(99) >= gap));
            prod = (idx < prods.size()) ? prods[idx] : 16'h0;
            @(negedge clk);
            if (acc_valid) break;
            rdy += int'(prod_ready);
            if (prod_valid && prod_ready) begin idx++; n_acc++; last = cyc; end
            cyc++;
            if (cyc > 2000) begin to = 1; break; end
            @(posedge clk); #1;
        end
        lat = cyc - last;
        prod_valid = 0;
        a24 = acc24; a17 = acc17; o24 = ovf24; o17 = ovf17;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (!acc_valid || acc24 !== a24 || acc17 !== a17 || ovf24 !== o24 || ovf17 !== o17) stable = 0;
        end
        @(posedge clk); #1;
        acc_ready = 1;
        @(negedge clk);
        if (!acc_valid) stable = 0;
        @(posedge clk); #1;
        acc_ready = 0; start = 0;
        @(negedge clk);
        idle_ok = !busy && !acc_valid && !prod_ready && acc24 === a24;
    endtask

    task automatic test_reset();
        rst = 1; start = 0; len = 0; prod = 0; prod_valid = 0; acc_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++; if (busy !== 1'b0 || prod_ready !== 1'b0 || acc_valid !== 1'b0) begin fails++; $display("FAIL reset_flags: busy=%b ready=%b valid=%b want 0 0 0", busy, prod_ready, acc_valid); end
        tests++; if (acc24 !== 24'h0 || ovf24 !== 1'b0) begin fails++; $display("FAIL reset_acc: acc=%h ovf=%b want 0 0", acc24, ovf24); end
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_basic();
        int na, lat, last, rdy; logic [23:0] a24; logic [16:0] a17; logic o24, o17; bit st, io, to;
        logic [31:0] e; logic eo;
        prods = {16'hFE01, 16'h0001, 16'h00FF};
        run_txn(3, 0, 0, 0, na, lat, last, a24, a17, o24, o17, st, io, rdy, to);
        tests++; if (na !== 3 || last !== 2) begin fails++; $display("FAIL basic_accepts: n=%0d last=%0d want 3 2", na, last); end
        tests++; if (lat !== 1 || to) begin fails++; $display("FAIL basic_latency: %0d want 1 (timeout=%0b)", lat, to); end
        tests++; if (a24 !== 24'h00FF01 || o24 !== 1'b0) begin fails++; $display("FAIL basic_acc: acc=%h ovf=%b want 00ff01 0", a24, o24); end
        model(3, 17, e, eo);
        tests++; if (a17 !== e[16:0] || o17 !== eo) begin fails++; $display("FAIL basic_acc17: acc=%h ovf=%b want %h %b", a17, o17, e[16:0], eo); end
        tests++; if (!io) begin fails++; $display("FAIL basic_idle: idle_ok=%0b want 1", io); end
    endtask

    task automatic test_backpressure();
        int na, lat, last, rdy; logic [23:0] a24; logic [16:0] a17; logic o24, o17; bit st, io, to;
        prods = {16'h0010, 16'h0020};
        run_txn(2, -1, 5, 0, na, lat, last, a24, a17, o24, o17, st, io, rdy, to);
        tests++; if (na !== 2 || last !== 3 || lat !== 1) begin fails++; $display("FAIL stall_accepts: n=%0d last=%0d lat=%0d want 2 3 1", na, last, lat); end
        tests++; if (a24 !== 24'h000030) begin fails++; $display("FAIL stall_acc: %h want 000030", a24); end
        tests++; if (!st) begin fails++; $display("FAIL hold_stable: stable=%0b want 1", st); end
        tests++; if (!io) begin fails++; $display("FAIL hold_idle: idle_ok=%0b want 1", io); end
    endtask

    task automatic test_overflow();
        int na, lat, last, rdy; logic [23:0] a24; logic [16:0] a17; logic o24, o17; bit st, io, to;
        logic [31:0] e; logic eo;
        prods = {16'hFE01, 16'hFE01, 16'hFE01};
        run_txn(3, 0, 2, 0, na, lat, last, a24, a17, o24, o17, st, io, rdy, to);
`ifdef ACC_SAT_EN
        tests++; if (a17 !== 17'h1FFFF || o17 !== 1'b1) begin fails++; $display("FAIL ovf17: acc=%h ovf=%b want 1ffff 1", a17, o17); end
`else
        tests++; if (a17 !== 17'h0FA03 || o17 !== 1'b1) begin fails++; $display("FAIL ovf17: acc=%h ovf=%b want 0fa03 1", a17, o17); end
`endif
        model(3, 24, e, eo);
        tests++; if (a24 !== e[23:0] || o24 !== eo) begin fails++; $display("FAIL ovf24: acc=%h ovf=%b want %h %b", a24, o24, e[23:0], eo); end
        tests++; if (!st) begin fails++; $display("FAIL ovf_stable: stable=%0b want 1", st); end
    endtask

    task automatic test_zero_len();
        int na, lat, last, rdy; logic [23:0] a24; logic [16:0] a17; logic o24, o17; bit st, io, to;
        prods = {};
        run_txn(0, 0, 1, 0, na, lat, last, a24, a17, o24, o17, st, io, rdy, to);
        tests++; if (lat !== 1 || to) begin fails++; $display("FAIL zero_latency: %0d want 1", lat); end
        tests++; if (a24 !== 24'h0 || a17 !== 17'h0 || o17 !== 1'b0) begin fails++; $display("FAIL zero_acc: acc=%h acc17=%h ovf17=%b want 0 0 0", a24, a17, o17); end
        tests++; if (rdy !== 0) begin fails++; $display("FAIL zero_ready: ready cycles=%0d want 0", rdy); end
    endtask

    task automatic test_mid_reset();
        int na, lat, last, rdy, n = 0; logic [23:0] a24; logic [16:0] a17; logic o24, o17; bit st, io, to;
        prods = {16'h1234, 16'h0F0F, 16'h00AA, 16'h0001};
        @(posedge clk); #1;
        start = 1; len = 8'd4;
        @(posedge clk); #1;
        start = 0; prod_valid = 1;
        for (int k = 0; k < 20 && n < 2; k++) begin
            prod = prods[n];
            @(negedge clk);
            if (prod_valid && prod_ready) n++;
            @(posedge clk); #1;
        end
        tests++; if (n !== 2) begin fails++; $display("FAIL midrst_accepts: %0d want 2", n); end
        rst = 1; prod_valid = 0;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        tests++; if (busy !== 1'b0 || prod_ready !== 1'b0 || acc24 !== 24'h0 || acc_valid !== 1'b0) begin fails++; $display("FAIL midrst_state: busy=%b ready=%b acc=%h valid=%b want 0 0 0 0", busy, prod_ready, acc24, acc_valid); end
        prods = {16'h0005};
        run_txn(1, 0, 0, 0, na, lat, last, a24, a17, o24, o17, st, io, rdy, to);
        tests++; if (a24 !== 24'h000005 || na !== 1) begin fails++; $display("FAIL midrst_rerun: acc=%h n=%0d want 000005 1", a24, na); end
    endtask

    task automatic test_ignored_start();
        int na, lat, last, rdy; logic [23:0] a24; logic [16:0] a17; logic o24, o17; bit st, io, to;
        prods = {16'h0042, 16'h0100, 16'h0200};
        run_txn(1, 0, 2, 1, na, lat, last, a24, a17, o24, o17, st, io, rdy, to);
        tests++; if (na !== 1 || a24 !== 24'h000042) begin fails++; $display("FAIL ign_start_run: n=%0d acc=%h want 1 000042", na, a24); end
        tests++; if (!io) begin fails++; $display("FAIL ign_start_idle: idle_ok=%0b want 1", io); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (busy !== 1'b0 || acc_valid !== 1'b0) begin fails++; $display("FAIL ign_start_second: busy=%b valid=%b want 0 0", busy, acc_valid); end
    endtask

    task automatic test_random();
        int na, lat, last, rdy, n; logic [23:0] a24; logic [16:0] a17; logic o24, o17; bit st, io, to;
        logic [31:0] e24, e17; logic eo24, eo17;
        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(0, 12);
            prods = {};
            for (int i = 0; i < n; i++) prods.push_back(16'($urandom));
            run_txn(n, 40, $urandom_range(0, 3), r[0], na, lat, last, a24, a17, o24, o17, st, io, rdy, to);
            model(n, 24, e24, eo24);
            model(n, 17, e17, eo17);
            tests++; if (na !== n || lat !== 1 || to) begin fails++; $display("FAIL rand%0d_handshake: n=%0d lat=%0d want %0d 1", r, na, lat, n); end
            tests++; if (a24 !== e24[23:0] || o24 !== eo24) begin fails++; $display("FAIL rand%0d_acc24: acc=%h ovf=%b want %h %b", r, a24, o24, e24[23:0], eo24); end
            tests++; if (a17 !== e17[16:0] || o17 !== eo17) begin fails++; $display("FAIL rand%0d_acc17: acc=%h ovf=%b want %h %b", r, a17, o17, e17[16:0], eo17); end
            tests++; if (!st || !io) begin fails++; $display("FAIL rand%0d_done: stable=%0b idle_ok=%0b want 1 1", r, st, io); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_zero_len();
        test_mid_reset();
        test_ignored_start();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
